// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches to the icache and
// buffers returned {pc, instruction} pairs for decode. Optional FETCH_PERF_EN adds stall/full counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ic_valid,
  output logic [31:0] ic_addr,
  input  logic        ic_ready,
  input  logic [31:0] ic_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_full_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {BUBBLE, FETCH} state_t;

  state_t             state, state_nxt;
  logic [31:0]        pc;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [PTR_W:0]     count;
  logic [31:0]        mem_pc   [FIFO_DEPTH];
  logic [31:0]        mem_data [FIFO_DEPTH];
  logic               push, pop;

  assign ic_valid   = (state == FETCH) && !redirect_valid && (count < FULL_CNT);
  assign ic_addr    = pc;
  assign push       = ic_valid && ic_ready;
  assign inst_valid = (count != '0);
  // A pop coinciding with a redirect is discarded along with the flush.
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  // Gated so the head reads as zero whenever the buffer is empty (including reset).
  assign inst_pc    = inst_valid ? mem_pc[rd_ptr]   : '0;
  assign inst_data  = inst_valid ? mem_data[rd_ptr] : '0;

  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    state_nxt = state;
    case (state)
      BUBBLE:  state_nxt = redirect_valid ? BUBBLE : FETCH;
      FETCH:   state_nxt = redirect_valid ? BUBBLE : FETCH;
      default: state_nxt = BUBBLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= BUBBLE;
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc     <= redirect_pc & ~32'h3;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= pc;
      mem_data[wr_ptr] <= ic_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating event counters; only reset clears them, redirects do not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      if (ic_valid && !ic_ready && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if ((state == FETCH) && (count == FULL_CNT) && (perf_full_cnt != 32'hFFFF_FFFF))
        perf_full_cnt <= perf_full_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (RESET_PC=0x100, FIFO_DEPTH=4).
// The icache responder returns addr ^ K so each instruction word is traceable to its PC.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ic_valid;
  logic [31:0] ic_addr;
  logic        ic_ready = 1'b0;
  logic [31:0] ic_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_full_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  fetch_unit #(.RESET_PC(32'h100), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ic_valid       (ic_valid),
    .ic_addr        (ic_addr),
    .ic_ready       (ic_ready),
    .ic_rdata       (ic_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_ready     (inst_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_full_cnt  (perf_full_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign ic_rdata = ic_addr ^ K;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, outputs sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    ic_ready = 1'b0;
    inst_ready = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset values, then sequential fetch with one-cycle buffer latency
    do_reset();
    #1;
    check("rst_ic_valid", {31'd0, ic_valid}, 32'd0);
    check("rst_ic_addr", ic_addr, 32'h100);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_inst_data", inst_data, 32'h0);
    ic_ready = 1'b1; inst_ready = 1'b1;
    cyc(); #1;
    check("t1_valid0", {31'd0, ic_valid}, 32'd1);
    check("t1_addr0", ic_addr, 32'h100);
    check("t1_inst_valid0", {31'd0, inst_valid}, 32'd0);
    cyc(); #1;
    check("t1_addr1", ic_addr, 32'h104);
    check("t1_inst_valid1", {31'd0, inst_valid}, 32'd1);
    check("t1_inst_pc1", inst_pc, 32'h100);
    check("t1_inst_data1", inst_data, 32'h100 ^ K);
    cyc(); #1;
    check("t1_addr2", ic_addr, 32'h108);
    check("t1_inst_pc2", inst_pc, 32'h104);

    // 2: backpressure fills the buffer; one pop releases exactly one fetch
    do_reset();
    ic_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      if (ic_valid && ic_ready) n++;
    end
    check("t2_transfers", n, 32'd4);
    check("t2_full_ic_valid", {31'd0, ic_valid}, 32'd0);
    check("t2_full_addr", ic_addr, 32'h110);
    check("t2_head_pc", inst_pc, 32'h100);
    cyc(); #1;
    check("t2_full_addr_hold", ic_addr, 32'h110);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    #1;
    check("t2_head_after_pop", inst_pc, 32'h104);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (ic_valid && ic_ready) n++;
      cyc(); #1;
    end
    check("t2_resume_transfers", n, 32'd1);
    check("t2_resume_addr", ic_addr, 32'h114);

    // 3: icache stall holds the address; single push when ready rises
    do_reset();
    inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1;
    check("t3_redir_ic_valid", {31'd0, ic_valid}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    check("t3_bubble_addr", ic_addr, 32'h200);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check("t3_stall_valid", {31'd0, ic_valid}, 32'd1);
      check("t3_stall_addr", ic_addr, 32'h200);
      check("t3_stall_empty", {31'd0, inst_valid}, 32'd0);
    end
    ic_ready = 1'b1;
    cyc();
    ic_ready = 1'b0;
    #1;
    check("t3_push_pc", inst_pc, 32'h200);
    check("t3_push_data", inst_data, 32'h200 ^ K);
    check("t3_next_addr", ic_addr, 32'h204);
    cyc(); #1;
    check("t3_no_dup", {31'd0, inst_valid}, 32'd0);

    // 4: redirect with three buffered entries flushes and restarts word-aligned
    do_reset();
    ic_ready = 1'b1;
    repeat (4) cyc();
    #1;
    check("t4_buffered", {31'd0, inst_valid}, 32'd1);
    check("t4_pre_addr", ic_addr, 32'h10C);
    redirect_valid = 1'b1; redirect_pc = 32'h803;
    #1;
    check("t4_redir_ic_valid", {31'd0, ic_valid}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    check("t4_flush_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("t4_bubble_ic_valid", {31'd0, ic_valid}, 32'd0);
    check("t4_bubble_addr", ic_addr, 32'h800);
    cyc(); #1;
    check("t4_fetch_valid", {31'd0, ic_valid}, 32'd1);
    check("t4_fetch_addr", ic_addr, 32'h800);
    inst_ready = 1'b1;
    cyc(); #1;
    check("t4_new_pc", inst_pc, 32'h800);
    check("t4_new_data", inst_data, 32'h800 ^ K);

    // 5: redirect coinciding with ready on both sides; back-to-back redirects; PC wrap
    do_reset();
    ic_ready = 1'b1; inst_ready = 1'b1;
    cyc(); cyc(); #1;
    check("t5_pre_inst_valid", {31'd0, inst_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    #1;
    check("t5_no_push", {31'd0, ic_valid}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    check("t5_empty", {31'd0, inst_valid}, 32'd0);
    check("t5_pc", ic_addr, 32'h400);
    redirect_valid = 1'b1; redirect_pc = 32'h500;
    cyc();
    redirect_pc = 32'h607;
    cyc();
    redirect_valid = 1'b0;
    #1;
    check("t5_b2b_addr", ic_addr, 32'h604);
    check("t5_b2b_bubble", {31'd0, ic_valid}, 32'd0);
    cyc(); #1;
    check("t5_b2b_fetch", {31'd0, ic_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    cyc();
    redirect_valid = 1'b0;
    cyc(); #1;
    check("t5_wrap_addr", ic_addr, 32'hFFFF_FFFC);
    cyc(); #1;
    check("t5_wrapped_addr", ic_addr, 32'h0);
    check("t5_wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);

    // Reset mid-operation behaves like power-on reset
    rst_n = 1'b0;
    cyc(); #1;
    check("mid_rst_addr", ic_addr, 32'h100);
    check("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("mid_rst_ic_valid", {31'd0, ic_valid}, 32'd0);
    rst_n = 1'b1;

`ifdef FETCH_PERF_EN
    // 6: stall counter counts, survives a redirect, clears on reset
    do_reset();
    #1;
    check("t6_rst_stall", perf_stall_cnt, 32'd0);
    check("t6_rst_full", perf_full_cnt, 32'd0);
    repeat (6) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    #1;
    check("t6_stall5", perf_stall_cnt, 32'd5);
    cyc();
    redirect_valid = 1'b0;
    #1;
    check("t6_after_redirect", perf_stall_cnt, 32'd5);
    rst_n = 1'b0;
    cyc(); #1;
    check("t6_after_reset", perf_stall_cnt, 32'd0);
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
